ksa4_result_checker: RTL and testbench
======================================

# ksa4_result_checker

Cycle-based response checker on the output side of the clocked 4-bit Kogge-Stone adder (KSA4) datapath. The stimulus side presents operands one GCLK cycle at a time. This block computes the golden sum for each operand vector and delays it by the DUT pipeline latency. It then compares that value with the DUT sum/cout bits sampled in the matching cycle and reports per-vector errors, spurious output activity and a final pass/fail summary. It sits beside the DUT in the post-route simulation harness and in on-chip self-test.

## Interface
Parameters:
- WIDTH, 4, operand/sum width in bits
- MAX_LAT, 15, deepest supported DUT latency in GCLK cycles; sets delay-line depth
- CNT_W, 16, width of vector and error counters

Ports:
- GCLK_Pad  in  1  global clock; all state updates on the rising edge
- rst_n_Pad  in  1  reset, asynchronous, active-low
- start  in  1  arm/restart the checker; clears counters; captures lat_cfg
- stop  in  1  end of stimulus; enters drain
- lat_cfg  in  4  DUT latency in cycles, 1..MAX_LAT; 0 is treated as 1
- stim_valid  in  1  an operand vector is applied this cycle
- stim_a, stim_b  in  WIDTH  operands
- stim_cin  in  1  carry-in
- dut_sum  in  WIDTH  DUT sum bits sampled this cycle (no pulse = 0)
- dut_cout  in  1  DUT carry-out sampled this cycle
- busy  out  1  state is RUN or DRAIN
- done  out  1  state is DONE
- pass  out  1  valid when done: err_cnt==0 and vec_cnt!=0
- err_pulse  out  1  mismatch or spurious output detected at the last edge
- spur_pulse  out  1  the error at the last edge was spurious (no expected vector)
- vec_cnt  out  CNT_W  vectors checked
- err_cnt  out  CNT_W  errors of both kinds
- first_err_idx  out  CNT_W  vec_cnt value at the first error
- exp_word  out  WIDTH+1  last compared expected {cout,sum}, for debug

## Operation
- State machine:
  - IDLE: waits for start.
  - start -> RUN: zero the counters, first_err_idx and delay line; latch lat_q = max(lat_cfg,1).
  - RUN: on stim_valid, push {1, a+b+cin} into the delay line; otherwise push {0,0}.
  - stop in RUN -> DRAIN: a down-counter is loaded with lat_q. New stim_valid pushes {0,0} and the vector is ignored.
  - DRAIN: comparisons continue. When the counter reaches 0 the state moves to DONE.
  - DONE: holds results until start or reset.
- start in any state restarts as above. start and stop in the same cycle: start wins. stop in IDLE or DONE is ignored.
- Arithmetic: exp = stim_a + stim_b + stim_cin, zero-extended to WIDTH+1 bits. Bit WIDTH is the expected cout.
- The delay line is a MAX_LAT-entry shift register. The tap is selected by lat_q.
- Comparison runs every edge in RUN and DRAIN on the tap entry {v, e}:
  - v=1: vec_cnt increments. If {dut_cout,dut_sum} != e, it is an error.
  - v=0: any nonzero dut bit is an error, flagged as spurious. vec_cnt is unchanged.
- On an error: err_cnt increments. first_err_idx is written only while err_cnt==0, with the vec_cnt value before the increment.
- Counters saturate at all-ones and do not wrap.
- Reset mid-operation: the block returns to IDLE at once, with all outputs at their reset values.

## Timing
- Reset values: busy=0, done=0, pass=0, err_pulse=0, spur_pulse=0, vec_cnt=0, err_cnt=0, first_err_idx=0, exp_word=0. The delay line is cleared.
- A vector sampled at edge n is compared with the DUT bits sampled at edge n+lat_q.
- err_pulse, spur_pulse, counters and exp_word are registered. They reflect that comparison during the cycle after edge n+lat_q.
- start sampled at edge k: busy=1 from edge k. A stim_valid sampled at edge k+1 is the first vector accepted.
- stop sampled at edge s: the tap entries compared at edges s+1 through s+lat_q are still checked. done=1 from edge s+lat_q+1.
- No input handshake exists. One vector per cycle, back-to-back, is supported.

## Test plan
- lat_cfg=2; vectors (a=2,b=3,cin=0), (6,1,0), (7,4,1); DUT model returns 5, 7, 12 two cycles later -> vec_cnt=3, err_cnt=0, done then pass=1.
- lat_cfg=2; vector (7,4,1); DUT returns 0x0C with cout forced to 1 -> err_pulse for one cycle, spur_pulse=0, err_cnt=1, first_err_idx=0, pass=0.
- No vectors; dut_sum=4'b0001 for one cycle in RUN -> err_pulse=1, spur_pulse=1, vec_cnt=0, pass=0 at done.
- lat_cfg=15 with 20 back-to-back vectors (a=i mod 16, b=15-i, cin=i[0]) and a matching DUT model -> vec_cnt=20, err_cnt=0, done exactly 16 cycles after stop.
- Mid-run: assert rst_n_Pad=0 for 1 cycle after 3 vectors -> all outputs 0 and IDLE. Then start with lat_cfg=0 -> behaves as latency 1 (vector (1,1,0) compared against dut=2 at the next edge).
- start and stop asserted together in RUN with err_cnt=2 -> counters cleared, busy=1, state RUN, no DONE.

Source files
------------

// File: rtl/ksa4_result_checker.sv
// Response checker for the clocked KSA4 adder: delays the golden sum by the
// DUT latency, compares against the sampled DUT bits and keeps error statistics.
module ksa4_result_checker #(
  parameter int WIDTH   = 4,
  parameter int MAX_LAT = 15,
  parameter int CNT_W   = 16
) (
  input  logic             GCLK_Pad,
  input  logic             rst_n_Pad,
  input  logic             start,
  input  logic             stop,
  input  logic [3:0]       lat_cfg,
  input  logic             stim_valid,
  input  logic [WIDTH-1:0] stim_a,
  input  logic [WIDTH-1:0] stim_b,
  input  logic             stim_cin,
  input  logic [WIDTH-1:0] dut_sum,
  input  logic             dut_cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             err_pulse,
  output logic             spur_pulse,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [WIDTH:0]   exp_word
);

  localparam int LW = $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                      state_q, state_d;
  logic [LW-1:0]               lat_q, lat_d;
  logic [LW-1:0]               drain_q, drain_d;
  logic [MAX_LAT-1:0]          vld_pipe_q, vld_pipe_d;
  logic [MAX_LAT-1:0][WIDTH:0] exp_pipe_q, exp_pipe_d;
  logic [CNT_W-1:0]            vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0]            err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]            first_err_q, first_err_d;
  logic [WIDTH:0]              exp_word_q, exp_word_d;
  logic                        err_pulse_q, err_pulse_d;
  logic                        spur_pulse_q, spur_pulse_d;

  logic [LW-1:0]  lat_eff;
  logic [LW-1:0]  tap_idx;
  logic [WIDTH:0] exp_new;
  logic [WIDTH:0] dut_word;
  logic           tap_v;
  logic [WIDTH:0] tap_e;
  logic           cmp_en;
  logic           mis;

  always_comb begin
    if (lat_cfg == 4'd0)                lat_eff = LW'(1);
    else if (int'(lat_cfg) > MAX_LAT)   lat_eff = LW'(MAX_LAT);
    else                                lat_eff = LW'(lat_cfg);

    exp_new  = {1'b0, stim_a} + {1'b0, stim_b} + {{WIDTH{1'b0}}, stim_cin};
    dut_word = {dut_cout, dut_sum};
    tap_idx  = lat_q - LW'(1);
    tap_v    = vld_pipe_q[tap_idx];
    tap_e    = exp_pipe_q[tap_idx];
    cmp_en   = (state_q == RUN || state_q == DRAIN) && !start;
    mis      = tap_v ? (dut_word != tap_e) : (dut_word != '0);

    state_d      = state_q;
    lat_d        = lat_q;
    drain_d      = drain_q;
    vld_pipe_d   = vld_pipe_q;
    exp_pipe_d   = exp_pipe_q;
    vec_cnt_d    = vec_cnt_q;
    err_cnt_d    = err_cnt_q;
    first_err_d  = first_err_q;
    exp_word_d   = exp_word_q;
    err_pulse_d  = cmp_en && mis;
    spur_pulse_d = cmp_en && mis && !tap_v;

    if (cmp_en) begin
      // Only RUN feeds real vectors; DRAIN keeps shifting bubbles through.
      for (int i = MAX_LAT - 1; i > 0; i--) begin
        vld_pipe_d[i] = vld_pipe_q[i-1];
        exp_pipe_d[i] = exp_pipe_q[i-1];
      end
      vld_pipe_d[0] = (state_q == RUN) && stim_valid;
      exp_pipe_d[0] = ((state_q == RUN) && stim_valid) ? exp_new : '0;

      if (tap_v) begin
        exp_word_d = tap_e;
        if (vec_cnt_q != '1) vec_cnt_d = vec_cnt_q + CNT_W'(1);
      end
      if (mis) begin
        if (err_cnt_q == '0) first_err_d = vec_cnt_q;
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
      end
    end

    case (state_q)
      RUN: if (stop) begin
        state_d = DRAIN;
        drain_d = lat_q;
      end
      DRAIN: begin
        if (drain_q == '0) state_d = DONE;
        else               drain_d = drain_q - LW'(1);
      end
      default: ;
    endcase

    // Restart has priority over everything, including a simultaneous stop.
    if (start) begin
      state_d     = RUN;
      lat_d       = lat_eff;
      drain_d     = '0;
      vld_pipe_d  = '0;
      exp_pipe_d  = '0;
      vec_cnt_d   = '0;
      err_cnt_d   = '0;
      first_err_d = '0;
      exp_word_d  = '0;
    end
  end

  always_ff @(posedge GCLK_Pad or negedge rst_n_Pad) begin
    if (!rst_n_Pad) begin
      state_q      <= IDLE;
      lat_q        <= LW'(1);
      drain_q      <= '0;
      vld_pipe_q   <= '0;
      exp_pipe_q   <= '0;
      vec_cnt_q    <= '0;
      err_cnt_q    <= '0;
      first_err_q  <= '0;
      exp_word_q   <= '0;
      err_pulse_q  <= 1'b0;
      spur_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lat_q        <= lat_d;
      drain_q      <= drain_d;
      vld_pipe_q   <= vld_pipe_d;
      exp_pipe_q   <= exp_pipe_d;
      vec_cnt_q    <= vec_cnt_d;
      err_cnt_q    <= err_cnt_d;
      first_err_q  <= first_err_d;
      exp_word_q   <= exp_word_d;
      err_pulse_q  <= err_pulse_d;
      spur_pulse_q <= spur_pulse_d;
    end
  end

  assign busy          = (state_q == RUN) || (state_q == DRAIN);
  assign done          = (state_q == DONE);
  assign pass          = done && (err_cnt_q == '0) && (vec_cnt_q != '0);
  assign err_pulse     = err_pulse_q;
  assign spur_pulse    = spur_pulse_q;
  assign vec_cnt       = vec_cnt_q;
  assign err_cnt       = err_cnt_q;
  assign first_err_idx = first_err_q;
  assign exp_word      = exp_word_q;

endmodule

// File: tb/tb_ksa4_result_checker.sv
// Directed bench for ksa4_result_checker: hand-computed vectors, DUT responses
// driven at the configured latency, immediate assertions on every check.
module tb_ksa4_result_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stop, stim_valid, stim_cin, dut_cout;
  logic [3:0]  lat_cfg, stim_a, stim_b, dut_sum;
  logic        busy, done, pass, err_pulse, spur_pulse;
  logic [15:0] vec_cnt, err_cnt, first_err_idx;
  logic [4:0]  exp_word;

  int n_vec = 0;
  int n_mis = 0;

  ksa4_result_checker dut (
    .GCLK_Pad(clk), .rst_n_Pad(rst_n), .start(start), .stop(stop),
    .lat_cfg(lat_cfg), .stim_valid(stim_valid), .stim_a(stim_a),
    .stim_b(stim_b), .stim_cin(stim_cin), .dut_sum(dut_sum),
    .dut_cout(dut_cout), .busy(busy), .done(done), .pass(pass),
    .err_pulse(err_pulse), .spur_pulse(spur_pulse), .vec_cnt(vec_cnt),
    .err_cnt(err_cnt), .first_err_idx(first_err_idx), .exp_word(exp_word)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b,
                       input logic c, input logic [3:0] s, input logic co);
    stim_valid = v; stim_a = a; stim_b = b; stim_cin = c;
    dut_sum = s; dut_cout = co;
  endtask

  task automatic idle_in();
    drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic do_start(input logic [3:0] lat);
    lat_cfg = lat; start = 1'b1; tick(); start = 1'b0;
  endtask

  initial begin
    logic [4:0] e;
    logic [3:0] bb;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; lat_cfg = 4'd0;
    idle_in();
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err_pulse", err_pulse, 0);
    chk("rst_vec_cnt", vec_cnt, 0);
    chk("rst_exp_word", exp_word, 0);

    // Three good vectors, latency 2
    do_start(4'd2);
    chk("t1_busy", busy, 1);
    drive(1, 4'd2, 4'd3, 0, 4'd0, 0); tick();
    drive(1, 4'd6, 4'd1, 0, 4'd0, 0); tick();
    drive(1, 4'd7, 4'd4, 1, 4'd5, 0); tick();
    chk("t1_vec1", vec_cnt, 1);
    chk("t1_exp1", exp_word, 5);
    drive(0, 4'd0, 4'd0, 0, 4'd7, 0); tick();
    drive(0, 4'd0, 4'd0, 0, 4'hC, 0); tick();
    chk("t1_vec3", vec_cnt, 3);
    chk("t1_exp3", exp_word, 5'h0C);
    chk("t1_errp", err_pulse, 0);
    idle_in(); stop = 1'b1; tick(); stop = 1'b0;
    tick(); tick();
    chk("t1_done_early", done, 0);
    tick();
    chk("t1_done", done, 1);
    chk("t1_pass", pass, 1);
    chk("t1_err_cnt", err_cnt, 0);

    // Forced cout mismatch
    do_start(4'd2);
    drive(1, 4'd7, 4'd4, 1, 4'd0, 0); tick();
    idle_in(); tick();
    drive(0, 4'd0, 4'd0, 0, 4'hC, 1); tick();
    chk("t2_errp", err_pulse, 1);
    chk("t2_spur", spur_pulse, 0);
    chk("t2_err_cnt", err_cnt, 1);
    chk("t2_first", first_err_idx, 0);
    chk("t2_vec", vec_cnt, 1);
    idle_in(); tick();
    chk("t2_errp_clr", err_pulse, 0);
    stop = 1'b1; tick(); stop = 1'b0;
    tick(); tick(); tick();
    chk("t2_done", done, 1);
    chk("t2_pass", pass, 0);

    // Spurious output with no vectors
    do_start(4'd2);
    drive(0, 4'd0, 4'd0, 0, 4'd1, 0); tick();
    chk("t3_errp", err_pulse, 1);
    chk("t3_spur", spur_pulse, 1);
    chk("t3_vec", vec_cnt, 0);
    idle_in(); stop = 1'b1; tick(); stop = 1'b0;
    tick(); tick(); tick();
    chk("t3_done", done, 1);
    chk("t3_pass", pass, 0);
    chk("t3_err_cnt", err_cnt, 1);

    // Latency 15, 20 back-to-back vectors; each sum is 15 + cin
    do_start(4'd15);
    for (int t = 1; t <= 35; t++) begin
      idle_in();
      if (t <= 20) begin
        bb = 4'd15 - 4'(t - 1);
        stim_valid = 1'b1; stim_a = 4'(t - 1); stim_b = bb;
        stim_cin = 1'((t - 1) & 1);
      end
      if (t >= 16) begin
        e = 5'd15 + 5'((t - 16) & 1);
        dut_sum = e[3:0]; dut_cout = e[4];
      end
      tick();
      if (t >= 16) chk("t4_errp", err_pulse, 0);
    end
    chk("t4_vec", vec_cnt, 20);
    chk("t4_err", err_cnt, 0);
    idle_in(); stop = 1'b1; tick(); stop = 1'b0;
    for (int j = 1; j <= 16; j++) begin
      tick();
      if (j == 15) chk("t4_done_15", done, 0);
      if (j == 16) chk("t4_done_16", done, 1);
    end
    chk("t4_pass", pass, 1);

    // Asynchronous reset mid-run, then lat_cfg=0 acts as latency 1
    do_start(4'd2);
    drive(1, 4'd1, 4'd1, 0, 4'd0, 0); tick();
    tick(); tick();
    rst_n = 1'b0; #1;
    chk("t5_busy", busy, 0);
    chk("t5_vec", vec_cnt, 0);
    chk("t5_err", err_cnt, 0);
    chk("t5_errp", err_pulse, 0);
    chk("t5_done", done, 0);
    idle_in(); tick();
    rst_n = 1'b1; tick();
    do_start(4'd0);
    drive(1, 4'd1, 4'd1, 0, 4'd0, 0); tick();
    drive(0, 4'd0, 4'd0, 0, 4'd2, 0); tick();
    chk("t5_l1_vec", vec_cnt, 1);
    chk("t5_l1_err", err_cnt, 0);
    chk("t5_l1_exp", exp_word, 2);

    // start+stop together in RUN: start wins
    drive(0, 4'd0, 4'd0, 0, 4'd1, 0); tick(); tick();
    chk("t6_err2", err_cnt, 2);
    idle_in(); start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    chk("t6_err_clr", err_cnt, 0);
    chk("t6_vec_clr", vec_cnt, 0);
    chk("t6_busy", busy, 1);
    tick(); tick(); tick();
    chk("t6_busy_hold", busy, 1);
    chk("t6_no_done", done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
